sync_timing_recover: RTL

//  Receive-side counterpart of the display sync generator. Watches active-high hs/vs from a

---
 rtl/sync_timing_recover.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sync_timing_recover.sv
// Receive-side timing recovery: measures line/frame geometry from hs/vs,
// regenerates source-aligned x/y/border and reports lock once geometry is stable.
module sync_timing_recover #(
    parameter int CW          = 12,
    parameter int XRES        = 640,
    parameter int XFPORCH     = 24,
    parameter int YRES        = 480,
    parameter int YFPORCH     = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          fbclk,
    input  logic          rst_b,
    input  logic          hs_in,
    input  logic          vs_in,
    output logic [CW-1:0] x_out,
    output logic [CW-1:0] y_out,
    output logic          border_out,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_sync,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_sync,
    output logic          frame_start,
    output logic          locked
);

    localparam int              MW       = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]   ONE      = CW'(1);
    localparam logic [CW-1:0]   X_RELOAD = CW'(XRES + XFPORCH + 1);
    localparam logic [CW-1:0]   Y_RELOAD = CW'(YRES + YFPORCH);
    localparam logic [CW-1:0]   X_LIM    = CW'(XRES);
    localparam logic [CW-1:0]   Y_LIM    = CW'(YRES);
    localparam logic [MW-1:0]   LOCK_TGT = MW'(LOCK_FRAMES);

    // index 0 = hs, index 1 = vs
    logic [1:0] sync_in;
    logic [1:0] sync_d_reg;
    logic [1:0] sync_rise;
    logic [1:0] sync_fall;

    assign sync_in = {vs_in, hs_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            assign sync_rise[gi] = sync_in[gi] & ~sync_d_reg[gi];
            assign sync_fall[gi] = ~sync_in[gi] & sync_d_reg[gi];
        end
    endgenerate

    logic hrise, hfall, vrise, vfall, hs_d;
    assign hrise = sync_rise[0];
    assign hfall = sync_fall[0];
    assign vrise = sync_rise[1];
    assign vfall = sync_fall[1];
    assign hs_d  = sync_d_reg[0];

    logic [CW-1:0]   hcnt_reg, hcnt_next;
    logic [CW-1:0]   hsw_reg, hsw_next;
    logic [CW-1:0]   vcnt_reg, vcnt_next;
    logic [CW-1:0]   vsw_reg, vsw_next;
    logic [CW-1:0]   h_total_reg, h_total_next;
    logic [CW-1:0]   h_sync_reg, h_sync_next;
    logic [CW-1:0]   v_total_reg, v_total_next;
    logic [CW-1:0]   v_sync_reg, v_sync_next;
    logic [CW-1:0]   x_reg, x_next;
    logic [CW-1:0]   y_reg, y_next;
    logic [MW-1:0]   match_reg, match_next;
    logic [4*CW-1:0] prev_reg, prev_next;
    logic [4*CW-1:0] snap;
    logic            locked_reg, locked_next;
    logic            frame_start_reg, frame_start_next;
    logic            line_end;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    // Regenerated column wraps at the measured line length; hrise reload takes priority.
    assign line_end = ~hrise & (h_total_reg != '0) & (x_reg == h_total_reg - ONE);

    // vcnt is the value v_total takes on this vrise, so the snapshot sees the fresh count.
    assign snap = {h_total_reg, h_sync_reg, vcnt_reg, v_sync_reg};

    always_comb begin
        hcnt_next        = hcnt_reg;
        hsw_next         = hsw_reg;
        vcnt_next        = vcnt_reg;
        vsw_next         = vsw_reg;
        h_total_next     = h_total_reg;
        h_sync_next      = h_sync_reg;
        v_total_next     = v_total_reg;
        v_sync_next      = v_sync_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        match_next       = match_reg;
        prev_next        = prev_reg;
        locked_next      = locked_reg;
        frame_start_next = vrise;

        if (hrise) begin
            hcnt_next    = '0;
            h_total_next = hcnt_reg + ONE;
        end else begin
            hcnt_next = sat_inc(hcnt_reg);
        end

        if (hrise) begin
            hsw_next = ONE;
        end else if (hs_in && hs_d) begin
            hsw_next = sat_inc(hsw_reg);
        end
        if (hfall) begin
            h_sync_next = hsw_reg;
        end

        if (vrise) begin
            v_total_next = vcnt_reg;
            vcnt_next    = hrise ? ONE : '0;
        end else if (hrise) begin
            vcnt_next = sat_inc(vcnt_reg);
        end

        if (vrise) begin
            vsw_next = hrise ? ONE : '0;
        end else if (hrise && vs_in) begin
            vsw_next = sat_inc(vsw_reg);
        end
        if (vfall) begin
            v_sync_next = vsw_reg;
        end

        if (hrise) begin
            x_next = X_RELOAD;
        end else if (line_end) begin
            x_next = '0;
        end else begin
            x_next = x_reg + ONE;
        end

        if (vrise) begin
            y_next = Y_RELOAD;
        end else if (line_end) begin
            y_next = (y_reg == v_total_reg - ONE) ? '0 : y_reg + ONE;
        end

        if (vrise) begin
            if (snap == prev_reg) begin
                match_next = (match_reg >= LOCK_TGT) ? LOCK_TGT : match_reg + MW'(1);
            end else begin
                match_next = '0;
            end
            prev_next   = snap;
            locked_next = (match_next == LOCK_TGT);
        end

        // A bad line length or a lost hs drops lock, overriding any frame match.
        if ((hrise && locked_reg && (hcnt_reg + ONE != h_total_reg)) || (hcnt_reg == CNT_MAX)) begin
            locked_next = 1'b0;
            match_next  = '0;
        end
    end

    always_ff @(posedge fbclk) begin
        if (!rst_b) begin
            sync_d_reg      <= '0;
            hcnt_reg        <= '0;
            hsw_reg         <= '0;
            vcnt_reg        <= '0;
            vsw_reg         <= '0;
            h_total_reg     <= '0;
            h_sync_reg      <= '0;
            v_total_reg     <= '0;
            v_sync_reg      <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            match_reg       <= '0;
            prev_reg        <= '0;
            locked_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            sync_d_reg      <= sync_in;
            hcnt_reg        <= hcnt_next;
            hsw_reg         <= hsw_next;
            vcnt_reg        <= vcnt_next;
            vsw_reg         <= vsw_next;
            h_total_reg     <= h_total_next;
            h_sync_reg      <= h_sync_next;
            v_total_reg     <= v_total_next;
            v_sync_reg      <= v_sync_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            match_reg       <= match_next;
            prev_reg        <= prev_next;
            locked_reg      <= locked_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign x_out       = x_reg;
    assign y_out       = y_reg;
    assign border_out  = (x_reg >= X_LIM) || (y_reg >= Y_LIM);
    assign h_total     = h_total_reg;
    assign h_sync      = h_sync_reg;
    assign v_total     = v_total_reg;
    assign v_sync      = v_sync_reg;
    assign frame_start = frame_start_reg;
    assign locked      = locked_reg;

endmodule
